// File: rtl/latch_pkg.sv
// Shared types and default parameter values for the latch output filter.
package latch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } wid_state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILT_CYCLES = 4;
   localparam int DEF_CNT_W       = 8;
   localparam int DEF_WID_W       = 8;

endpackage

// File: rtl/latch_out_filter_bit_sync.sv
// Multi-flop synchronizer bringing an asynchronous single bit into the clk domain.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/latch_out_filter.sv
// Synchronizes and deglitches latch output f, reports edges, rise count and high-pulse width.
//
//  state | meaning
//  IDLE  | f_clean low, no pulse being measured
//  MEAS  | f_clean high, wid_cnt accumulating the high time
module latch_out_filter
   import latch_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_CYCLES = DEF_FILT_CYCLES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int WID_W       = DEF_WID_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             f_async,
   input  logic             cnt_clear,
   output logic             f_clean,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] evt_count,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [WID_W-1:0] rpt_width,
   output logic             rpt_ovf
);

   localparam int               FLT_W    = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [WID_W-1:0] WID_MAX  = '1;

   logic             f_sync;
   logic [FLT_W-1:0] flt_cnt;
   logic [WID_W-1:0] wid_cnt;
   wid_state_t       state;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (f_async),
      .q     (f_sync)
   );

   // A new level must persist FILT_CYCLES consecutive cycles; any agreeing cycle restarts the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_cnt <= '0;
         f_clean <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (f_sync == f_clean) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_LAST) begin
            flt_cnt <= '0;
            f_clean <= f_sync;
            rise    <= f_sync;
            fall    <= ~f_sync;
         end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_count <= '0;
      end else if (cnt_clear) begin
         evt_count <= rise ? CNT_W'(1) : '0;
      end else if (rise && (evt_count != CNT_MAX)) begin
         evt_count <= evt_count + CNT_W'(1);
      end
   end

   // A fall may load the slot in the same cycle the consumer drains it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wid_cnt   <= '0;
         rpt_valid <= 1'b0;
         rpt_width <= '0;
         rpt_ovf   <= 1'b0;
      end else begin
         if (rpt_valid && rpt_ready) begin
            rpt_valid <= 1'b0;
         end
         if (cnt_clear) begin
            rpt_ovf <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (rise) begin
                  state   <= MEAS;
                  wid_cnt <= WID_W'(1);
               end
            end
            MEAS: begin
               if (fall) begin
                  state <= IDLE;
                  if (!rpt_valid || rpt_ready) begin
                     rpt_valid <= 1'b1;
                     rpt_width <= wid_cnt;
                  end else begin
                     rpt_ovf <= 1'b1;
                  end
               end else if (f_clean && (wid_cnt != WID_MAX)) begin
                  wid_cnt <= wid_cnt + WID_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_out_filter.sv
// Testbench for latch_out_filter: directed scenarios plus randomized run against a reference model.
module tb_latch_out_filter;

   localparam int S  = 2;
   localparam int F  = 4;
   localparam int CW = 8;
   localparam int WW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          f_async = 1'b0;
   logic          cnt_clear = 1'b0;
   logic          rpt_ready = 1'b0;
   logic          f_clean, rise, fall, rpt_valid, rpt_ovf;
   logic [CW-1:0] evt_count;
   logic [WW-1:0] rpt_width;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // reference model state
   bit fq[$];
   bit m_clean, m_rise, m_fall, m_rv, m_ovf;
   int m_cnt, m_hi, m_rw;

   latch_out_filter #(
      .SYNC_STAGES (S),
      .FILT_CYCLES (F),
      .CNT_W       (CW),
      .WID_W       (WW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .f_async   (f_async),
      .cnt_clear (cnt_clear),
      .f_clean   (f_clean),
      .rise      (rise),
      .fall      (fall),
      .evt_count (evt_count),
      .rpt_valid (rpt_valid),
      .rpt_ready (rpt_ready),
      .rpt_width (rpt_width),
      .rpt_ovf   (rpt_ovf)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      fq.delete();
      m_clean = 0; m_rise = 0; m_fall = 0; m_rv = 0; m_ovf = 0;
      m_cnt = 0; m_hi = 0; m_rw = 0;
   endtask

   // One clock edge of the spec's behaviour: f_clean follows the synced input once the last
   // F synced samples (the ones S edges old and older) all show the opposite level.
   task automatic model_step();
      bit r, fl, cl, rv, tog;
      r = m_rise; fl = m_fall; cl = m_clean; rv = m_rv;
      fq.push_back(f_async);
      if (fq.size() > S + F) void'(fq.pop_front());
      if (cnt_clear) begin
         m_cnt = r ? 1 : 0;
         m_ovf = 0;
      end else if (r && m_cnt < 255) begin
         m_cnt++;
      end
      if (rv && rpt_ready) m_rv = 0;
      if (fl) begin
         if (!rv || rpt_ready) begin
            m_rv = 1;
            m_rw = m_hi;
         end else begin
            m_ovf = 1;
         end
         m_hi = 0;
      end else if (cl && m_hi < 255) begin
         m_hi++;
      end
      tog = (fq.size() == S + F);
      for (int i = 0; i < F; i++) if (fq[i] == cl) tog = 0;
      m_rise = tog && !cl;
      m_fall = tog && cl;
      if (tog) m_clean = !cl;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_reset();
      tick(); tick();
      total_cnt++;
      if ({f_clean, rise, fall, evt_count, rpt_valid, rpt_width, rpt_ovf} !== '0)
         $display("FAIL reset_state: got clean=%b rise=%b fall=%b cnt=%0d v=%b w=%0d ovf=%b, need all 0",
                  f_clean, rise, fall, evt_count, rpt_valid, rpt_width, rpt_ovf);
      else pass_cnt++;
      rst_n = 1;
      tick();
   endtask

   task automatic test_rise_latency();
      int lat = 0;
      rpt_ready = 1;
      f_async = 1;
      while (f_clean !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      total_cnt++;
      if (lat != 6) $display("FAIL rise_latency: got %0d cycles, need 6", lat);
      else pass_cnt++;
      total_cnt++;
      if (rise !== 1'b1 || fall !== 1'b0) $display("FAIL rise_pulse: rise=%b fall=%b, need 1/0", rise, fall);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (rise !== 1'b0 || evt_count !== 8'd1)
         $display("FAIL rise_count: rise=%b cnt=%0d, need 0/1", rise, evt_count);
      else pass_cnt++;
      for (int i = lat + 1; i < 10; i++) tick();
      f_async = 0;
      for (int i = 0; i < 14; i++) tick();
   endtask

   task automatic test_glitch();
      logic [CW-1:0] c0;
      bit seen = 0;
      c0 = evt_count;
      f_async = 1;
      for (int i = 0; i < 3; i++) tick();
      f_async = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (f_clean || rise || fall) seen = 1;
      end
      total_cnt++;
      if (seen) $display("FAIL glitch_filtered: activity seen on f_clean/rise/fall, need none");
      else pass_cnt++;
      total_cnt++;
      if (evt_count !== c0) $display("FAIL glitch_count: got %0d, need %0d", evt_count, c0);
      else pass_cnt++;
   endtask

   task automatic test_width_ready();
      int vcyc = 0, w = -1;
      bit saw_fall = 0;
      rpt_ready = 1;
      f_async = 1;
      for (int i = 0; i < 20; i++) tick();
      f_async = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (fall) saw_fall = 1;
         if (rpt_valid) begin
            vcyc++;
            w = int'(rpt_width);
         end
      end
      total_cnt++;
      if (!saw_fall) $display("FAIL fall_pulse: no fall pulse seen");
      else pass_cnt++;
      total_cnt++;
      if (vcyc != 1 || w != 20) $display("FAIL width_report: valid_cycles=%0d width=%0d, need 1/20", vcyc, w);
      else pass_cnt++;
      total_cnt++;
      if (rpt_ovf !== 1'b0) $display("FAIL ovf_clear: got %b, need 0", rpt_ovf);
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      rpt_ready = 0;
      f_async = 1; for (int i = 0; i < 12; i++) tick();
      f_async = 0; for (int i = 0; i < 10; i++) tick();
      f_async = 1; for (int i = 0; i < 7; i++) tick();
      f_async = 0; for (int i = 0; i < 12; i++) tick();
      total_cnt++;
      if (rpt_valid !== 1'b1 || rpt_width !== 8'd12 || rpt_ovf !== 1'b1)
         $display("FAIL overflow_hold: v=%b w=%0d ovf=%b, need 1/12/1", rpt_valid, rpt_width, rpt_ovf);
      else pass_cnt++;
      rpt_ready = 1;
      tick();
      total_cnt++;
      if (rpt_valid !== 1'b0 || rpt_ovf !== 1'b1)
         $display("FAIL overflow_drain: v=%b ovf=%b, need 0/1", rpt_valid, rpt_ovf);
      else pass_cnt++;
   endtask

   task automatic test_saturate();
      int guard = 0, w = -1;
      rpt_ready = 1;
      for (int p = 0; p < 256; p++) begin
         f_async = 1; for (int i = 0; i < 5; i++) tick();
         f_async = 0; for (int i = 0; i < 5; i++) tick();
      end
      for (int i = 0; i < 8; i++) tick();
      total_cnt++;
      if (evt_count !== 8'd255) $display("FAIL count_saturate: got %0d, need 255", evt_count);
      else pass_cnt++;
      f_async = 1;
      while (rise !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      total_cnt++;
      if (rise !== 1'b1) $display("FAIL clear_rise_wait: rise not seen within %0d cycles", guard);
      else pass_cnt++;
      cnt_clear = 1;
      tick();
      cnt_clear = 0;
      total_cnt++;
      if (evt_count !== 8'd1 || rpt_ovf !== 1'b0)
         $display("FAIL clear_with_rise: cnt=%0d ovf=%b, need 1/0", evt_count, rpt_ovf);
      else pass_cnt++;
      for (int i = 0; i < 300; i++) tick();
      f_async = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (rpt_valid) w = int'(rpt_width);
      end
      total_cnt++;
      if (w != 255) $display("FAIL width_saturate: got %0d, need 255", w);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat = 0;
      bit stale = 0;
      f_async = 1;
      for (int i = 0; i < 10; i++) tick();
      total_cnt++;
      if (f_clean !== 1'b1) $display("FAIL mid_pre: f_clean=%b, need 1", f_clean);
      else pass_cnt++;
      #2 rst_n = 0;
      model_reset();
      #1;
      total_cnt++;
      if ({f_clean, rise, fall, evt_count, rpt_valid, rpt_width, rpt_ovf} !== '0)
         $display("FAIL async_reset: got clean=%b rise=%b fall=%b cnt=%0d v=%b w=%0d ovf=%b, need all 0",
                  f_clean, rise, fall, evt_count, rpt_valid, rpt_width, rpt_ovf);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1;
      while (rise !== 1'b1 && lat < 20) begin
         tick();
         lat++;
         if (rpt_valid) stale = 1;
      end
      total_cnt++;
      if (lat != 6) $display("FAIL release_latency: got %0d cycles, need 6", lat);
      else pass_cnt++;
      total_cnt++;
      if (stale || rpt_ovf) $display("FAIL stale_report: valid seen=%b ovf=%b, need 0/0", stale, rpt_ovf);
      else pass_cnt++;
      f_async = 0;
      for (int i = 0; i < 14; i++) tick();
   endtask

   task automatic test_random();
      int run = 0;
      for (int c = 0; c < 800; c++) begin
         if (run == 0) begin
            f_async = ~f_async;
            run = $urandom_range(1, 8);
         end
         run--;
         rpt_ready = ($urandom_range(0, 3) != 0);
         cnt_clear = ($urandom_range(0, 49) == 0);
         tick();
         total_cnt++;
         if ({f_clean, rise, fall, evt_count, rpt_valid, rpt_width, rpt_ovf} !==
             {m_clean, m_rise, m_fall, CW'(m_cnt), m_rv, WW'(m_rw), m_ovf})
            $display("FAIL random_cycle_%0d: got clean=%b r=%b f=%b cnt=%0d v=%b w=%0d ovf=%b, need clean=%b r=%b f=%b cnt=%0d v=%b w=%0d ovf=%b",
                     c, f_clean, rise, fall, evt_count, rpt_valid, rpt_width, rpt_ovf,
                     m_clean, m_rise, m_fall, m_cnt, m_rv, m_rw, m_ovf);
         else pass_cnt++;
      end
      cnt_clear = 0;
   endtask

   initial begin
      test_reset();
      test_rise_latency();
      test_glitch();
      test_width_ready();
      test_overflow();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
